// File: rtl/uart_pkg.sv
// Shared UART constants and encodings used by the receiver,
// transmitter and their byte FIFOs.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int RX_FIFO_ADDR_W = 4;
  localparam int RX_FIFO_DEPTH  = 1 << RX_FIFO_ADDR_W;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte RAM: synchronous write, asynchronous read.
// No reset on the storage array.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: first-word-fall-through, level, threshold
// interrupt and sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = RX_FIFO_ADDR_W,
  parameter int DEPTH  = RX_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              a_resetn,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovr_clr,
  input  logic [ADDR_W:0]   thresh,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              thresh_irq
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_d;
  logic              ovr_q, ovr_d;
  logic              irq_q, irq_d;
  logic              push, pop, drop;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop on a full FIFO frees the slot the push needs.
  assign push = rx_done && (!full || rd_en);
  assign pop  = rd_en && !empty;
  assign drop = rx_done && full && !rd_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovr_d    = ovr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop && !flush) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    cnt_d = wr_ptr_d - rd_ptr_d;
    irq_d = (thresh != '0) && (cnt_d >= thresh);
  end

  always_ff @(posedge clk) begin
    if (a_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
    end
  end

  assign mem_we = push && !flush && !a_resetn;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  assign dout       = empty ? '0 : mem_rdata;
  assign overrun    = ovr_q;
  assign thresh_irq = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed vector bench for uart_rx_fifo: table-driven single
// cycles plus hand-written fill, wrap, flush and reset sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       a_resetn;
  logic       rx_done;
  logic [7:0] din;
  logic       rd_en;
  logic       flush;
  logic       ovr_clr;
  logic [4:0] thresh;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       thresh_irq;

  int total  = 0;
  int passed = 0;

  uart_rx_fifo dut (
    .clk        (clk),
    .a_resetn   (a_resetn),
    .rx_done    (rx_done),
    .din        (din),
    .rd_en      (rd_en),
    .flush      (flush),
    .ovr_clr    (ovr_clr),
    .thresh     (thresh),
    .dout       (dout),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .thresh_irq (thresh_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rs;
    logic       rx;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       oc;
    logic [4:0] th;
    logic [7:0] e_dout;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_cnt;
    logic       e_ovr;
    logic       e_irq;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input string nm, input logic rs, input logic rx,
    input logic [7:0] d, input logic rd, input logic fl,
    input logic oc, input logic [4:0] th,
    input logic [7:0] e_dout, input logic e_empty,
    input logic e_full, input logic [4:0] e_cnt,
    input logic e_ovr, input logic e_irq);
    vec_t v;
    v.name = nm; v.rs = rs; v.rx = rx; v.d = d;
    v.rd = rd; v.fl = fl; v.oc = oc; v.th = th;
    v.e_dout = e_dout; v.e_empty = e_empty;
    v.e_full = e_full; v.e_cnt = e_cnt;
    v.e_ovr = e_ovr; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic cyc(input logic rs, input logic rx,
                     input logic [7:0] d, input logic rd,
                     input logic fl, input logic oc);
    a_resetn = rs;
    rx_done  = rx;
    din      = d;
    rd_en    = rd;
    flush    = fl;
    ovr_clr  = oc;
    @(posedge clk);
    #1;
    a_resetn = 1'b0;
    rx_done  = 1'b0;
    rd_en    = 1'b0;
    flush    = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [7:0] e_dout,
                     input logic e_empty, input logic e_full,
                     input logic [4:0] e_cnt, input logic e_ovr,
                     input logic e_irq);
    total++;
    if (dout === e_dout && empty === e_empty &&
        full === e_full && count === e_cnt &&
        overrun === e_ovr && thresh_irq === e_irq) begin
      passed++;
    end else begin
      $display("FAIL %s: got dout=%h empty=%b full=%b cnt=%0d ovr=%b irq=%b want dout=%h empty=%b full=%b cnt=%0d ovr=%b irq=%b",
               nm, dout, empty, full, count, overrun, thresh_irq,
               e_dout, e_empty, e_full, e_cnt, e_ovr, e_irq);
    end
  endtask

  initial begin
    a_resetn = 1'b0;
    rx_done  = 1'b0;
    din      = '0;
    rd_en    = 1'b0;
    flush    = 1'b0;
    ovr_clr  = 1'b0;
    thresh   = '0;

    //            name         rs rx din    rd fl oc th  dout  em fu cnt ov irq
    tv.push_back(mk("reset",    1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    tv.push_back(mk("push_a5",  0, 1, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0, 1, 0, 0));
    tv.push_back(mk("pop_a5",   0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    tv.push_back(mk("pop_empty",0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    tv.push_back(mk("th_push1", 0, 1, 8'h11, 0, 0, 0, 4, 8'h11, 0, 0, 1, 0, 0));
    tv.push_back(mk("th_push2", 0, 1, 8'h22, 0, 0, 0, 4, 8'h11, 0, 0, 2, 0, 0));
    tv.push_back(mk("th_push3", 0, 1, 8'h33, 0, 0, 0, 4, 8'h11, 0, 0, 3, 0, 0));
    tv.push_back(mk("th_push4", 0, 1, 8'h44, 0, 0, 0, 4, 8'h11, 0, 0, 4, 0, 1));
    tv.push_back(mk("th_pop",   0, 0, 8'h00, 1, 0, 0, 4, 8'h22, 0, 0, 3, 0, 0));
    tv.push_back(mk("th0_push", 0, 1, 8'h55, 0, 0, 0, 0, 8'h22, 0, 0, 4, 0, 0));
    tv.push_back(mk("th3_idle", 0, 0, 8'h00, 0, 0, 0, 3, 8'h22, 0, 0, 4, 0, 1));
    tv.push_back(mk("flush",    0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    tv.push_back(mk("pp_empty", 0, 1, 8'h66, 1, 0, 0, 0, 8'h66, 0, 0, 1, 0, 0));
    tv.push_back(mk("pp_one",   0, 1, 8'h77, 1, 0, 0, 0, 8'h77, 0, 0, 1, 0, 0));
    tv.push_back(mk("clr_pop",  0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tv[i]) begin
      thresh = tv[i].th;
      cyc(tv[i].rs, tv[i].rx, tv[i].d, tv[i].rd, tv[i].fl, tv[i].oc);
      chk(tv[i].name, tv[i].e_dout, tv[i].e_empty, tv[i].e_full,
          tv[i].e_cnt, tv[i].e_ovr, tv[i].e_irq);
    end

    // Fill, overflow, set-beats-clear, ordered drain
    thresh = '0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'(i), 0, 0, 0);
      chk("fill", 8'h00, 0, (i == 15), 5'(i + 1), 0, 0);
    end
    cyc(0, 1, 8'h55, 0, 0, 0);
    chk("drop", 8'h00, 0, 1, 16, 1, 0);
    cyc(0, 1, 8'h99, 0, 0, 1);
    chk("drop_vs_clr", 8'h00, 0, 1, 16, 1, 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain", 8'(i), 0, (i == 0), 5'(16 - i), 1, 0);
      cyc(0, 0, 8'h00, 1, 0, 0);
    end
    chk("drained", 8'h00, 1, 0, 0, 1, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("ovr_clr", 8'h00, 1, 0, 0, 0, 0);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'(8'h80 + i), 0, 0, 0);
    end
    chk("refill", 8'h80, 0, 1, 16, 0, 0);
    cyc(0, 1, 8'h77, 1, 0, 0);
    chk("full_pp", 8'h81, 0, 1, 16, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("full_pp_drain", (i < 15) ? 8'(8'h81 + i) : 8'h77,
          0, (i == 0), 5'(16 - i), 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0);
    end
    chk("full_pp_empty", 8'h00, 1, 0, 0, 0, 0);

    // Pointer wrap with one-deep traffic
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 8'(i * 7 + 3), 0, 0, 0);
      chk("wrap_push", 8'(i * 7 + 3), 0, 0, 1, 0, 0);
      cyc(0, 0, 8'h00, 1, 0, 0);
      chk("wrap_pop", 8'h00, 1, 0, 0, 0, 0);
    end

    // Flush leaves a set overrun alone
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 8'(i), 0, 0, 0);
    end
    chk("ovr_again", 8'h00, 0, 1, 16, 1, 0);
    cyc(0, 1, 8'hEE, 0, 1, 0);
    chk("flush_full", 8'h00, 1, 0, 0, 1, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    chk("ovr_clr2", 8'h00, 1, 0, 0, 0, 0);

    // Flush with rx_done at count 5
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'(8'hC0 + i), 0, 0, 0);
    end
    chk("five", 8'hC0, 0, 0, 5, 0, 0);
    cyc(0, 1, 8'hEE, 0, 1, 0);
    chk("flush_rx", 8'h00, 1, 0, 0, 0, 0);

    // Mid-stream reset at count 7
    thresh = 5'd1;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 8'(8'hD0 + i), 0, 0, 0);
    end
    chk("seven", 8'hD0, 0, 0, 7, 0, 1);
    cyc(1, 1, 8'hAB, 1, 0, 0);
    chk("mid_reset", 8'h00, 1, 0, 0, 0, 0);
    cyc(0, 1, 8'h3C, 0, 0, 0);
    chk("post_reset", 8'h3C, 0, 0, 1, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
